// File: rtl/rv_pkg.sv
// Shared definitions for the register-file write side.
//   XLEN       : data width of a register-file write
//   AW         : register index width (32 architectural registers)
//   REG_X0     : hard-wired zero register; writes to it are dropped
//   wb_entry_t : one pending write as it sits in the ALU result queue
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  localparam logic [AW-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd_sel;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular FIFO holding pending ALU writes.
// Every slot carries a valid bit so the owner can scan all in-flight
// destinations (hazard detection) without walking the pointers.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_data at the tail (caller guarantees not full)
//   push_data    : entry payload, key field in the top KeyW bits
//   pop          : drop the head entry (caller guarantees not empty)
//   head_data    : payload of the head entry
//   count        : occupancy, 0..Depth
//   entry_valid  : per-slot valid bits
//   entry_key    : per-slot top KeyW bits of the payload (the destination index)
module wb_fifo #(
  parameter int unsigned Depth = 4,   // power of two, >= 2
  parameter int unsigned Width = 37,
  parameter int unsigned KeyW  = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [Width-1:0]                 push_data,
  input  logic                             pop,
  output logic [Width-1:0]                 head_data,
  output logic [$clog2(Depth):0]           count,
  output logic [Depth-1:0]                 entry_valid,
  output logic [Depth-1:0][KeyW-1:0]       entry_key
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]             count_q, count_d;
  logic [Depth-1:0]            valid_q, valid_d;
  logic [Depth-1:0][Width-1:0] mem_q;

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset: a slot is only observed while its valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    head_data   = mem_q[rd_ptr_q];
    count       = count_q;
    entry_valid = valid_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      entry_key[i] = mem_q[i][Width-1 -: KeyW];
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-side front end of the 32x32 register file.
// Merges single-cycle ALU results and variable-latency load results into the
// one register-file write port, one write per cycle, and answers decode's
// "is this source register still being written?" question.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   alu_valid/ready/rd_sel/data : ALU result handshake (queued when busy)
//   ld_valid/ready/rd_sel/data  : load result handshake (held until accepted)
//   wb_we, wb_rd_sel, wb_rd   : registered register-file write port
//   chk_rs1_sel, chk_rs2_sel  : decode source indices to check
//   hazard                    : a checked source has a pending write
//   fifo_count                : ALU queue occupancy (debug)
module rf_wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = rv_pkg::XLEN,
  parameter int unsigned AW    = rv_pkg::AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_rd_sel,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [AW-1:0]            ld_rd_sel,
  input  logic [XLEN-1:0]          ld_data,
  output logic                     wb_we,
  output logic [AW-1:0]            wb_rd_sel,
  output logic [XLEN-1:0]          wb_rd,
  input  logic [AW-1:0]            chk_rs1_sel,
  input  logic [AW-1:0]            chk_rs2_sel,
  output logic                     hazard,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  import rv_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = AW + XLEN;

  localparam logic [AW-1:0] X0 = AW'(REG_X0);

  // ALU queue
  logic                        fifo_push;
  logic                        fifo_pop;
  logic [EW-1:0]               fifo_head;
  logic [DEPTH-1:0]            entry_valid;
  logic [DEPTH-1:0][AW-1:0]    entry_rd_sel;
  logic                        fifo_empty;
  logic                        alu_hs;

  // Selected source for the write-back stage
  logic                        sel_valid;
  logic [AW-1:0]               sel_rd_sel;
  logic [XLEN-1:0]             sel_data;

  // Write-back stage
  logic                        wb_we_q;
  logic [AW-1:0]               wb_rd_sel_q;
  logic [XLEN-1:0]             wb_rd_q;

  logic                        rs1_hit;
  logic                        rs2_hit;

  wb_fifo #(
    .Depth (DEPTH),
    .Width (EW),
    .KeyW  (AW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (fifo_push),
    .push_data   ({alu_rd_sel, alu_data}),
    .pop         (fifo_pop),
    .head_data   (fifo_head),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entry_key   (entry_rd_sel)
  );

  // Readiness depends on registered occupancy only, never on this cycle's dequeue.
  assign fifo_empty = (fifo_count == '0);
  assign alu_ready  = (fifo_count < CW'(DEPTH));
  assign ld_ready   = fifo_empty;
  assign alu_hs     = alu_valid && alu_ready;

  // Source priority: queued ALU results drain first so ALU order is kept;
  // a load may only enter when nothing older is queued, so a load accepted
  // before an ALU result always retires before it.
  always_comb begin
    sel_valid  = 1'b0;
    sel_rd_sel = '0;
    sel_data   = '0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;

    if (!fifo_empty) begin
      fifo_pop                = 1'b1;
      sel_valid               = 1'b1;
      {sel_rd_sel, sel_data}  = fifo_head;
      fifo_push               = alu_hs;
    end else if (ld_valid) begin
      sel_valid  = 1'b1;
      sel_rd_sel = ld_rd_sel;
      sel_data   = ld_data;
      fifo_push  = alu_hs;
    end else if (alu_hs) begin
      // Empty queue and no load: bypass straight into the write-back stage.
      sel_valid  = 1'b1;
      sel_rd_sel = alu_rd_sel;
      sel_data   = alu_data;
    end
  end

  // x0 targets are consumed like any other result but never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q     <= 1'b0;
      wb_rd_sel_q <= '0;
      wb_rd_q     <= '0;
    end else if (sel_valid) begin
      wb_we_q     <= (sel_rd_sel != X0);
      wb_rd_sel_q <= sel_rd_sel;
      wb_rd_q     <= sel_data;
    end else begin
      wb_we_q     <= 1'b0;
    end
  end

  assign wb_we     = wb_we_q;
  assign wb_rd_sel = wb_rd_sel_q;
  assign wb_rd     = wb_rd_q;

  // Pending writes live either in the write-back stage or in a valid queue slot.
  // Results still sitting on the alu_*/ld_* inputs are the issue logic's concern.
  always_comb begin
    rs1_hit = wb_we_q && (wb_rd_sel_q == chk_rs1_sel);
    rs2_hit = wb_we_q && (wb_rd_sel_q == chk_rs2_sel);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_rd_sel[i] == chk_rs1_sel)) begin
        rs1_hit = 1'b1;
      end
      if (entry_valid[i] && (entry_rd_sel[i] == chk_rs2_sel)) begin
        rs2_hit = 1'b1;
      end
    end
    hazard = (rs1_hit && (chk_rs1_sel != X0)) || (rs2_hit && (chk_rs2_sel != X0));
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized bench for rf_wb_arbiter.
// A queue-based reference tracks queued ALU results and the write-back stage;
// an independent acceptance-order scoreboard checks every retired write.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd_sel;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd_sel;
  logic [XLEN-1:0] ld_data;
  logic            wb_we;
  logic [AW-1:0]   wb_rd_sel;
  logic [XLEN-1:0] wb_rd;
  logic [AW-1:0]   chk_rs1_sel;
  logic [AW-1:0]   chk_rs2_sel;
  logic            hazard;
  logic [CW-1:0]   fifo_count;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .AW    (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd_sel  (alu_rd_sel),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd_sel   (ld_rd_sel),
    .ld_data     (ld_data),
    .wb_we       (wb_we),
    .wb_rd_sel   (wb_rd_sel),
    .wb_rd       (wb_rd),
    .chk_rs1_sel (chk_rs1_sel),
    .chk_rs2_sel (chk_rs2_sel),
    .hazard      (hazard),
    .fifo_count  (fifo_count)
  );

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] d;
  } wr_t;

  int checks = 0;
  int errors = 0;

  wr_t             fq[$];     // ALU results waiting behind the write-back stage
  wr_t             ret_q[$];  // accepted non-x0 writes, in acceptance order
  logic            m_we;
  logic [AW-1:0]   m_sel;
  logic [XLEN-1:0] m_rd;
  logic [XLEN-1:0] rf_dut [32];
  bit              ld_acc;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_match(input logic [AW-1:0] s);
    if (s == '0) return 1'b0;
    if (m_we && m_sel == s) return 1'b1;
    foreach (fq[i]) if (fq[i].rd == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    fq.delete();
    ret_q.delete();
    m_we  = 1'b0;
    m_sel = '0;
    m_rd  = '0;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  // One clock with the inputs currently driven.
  task automatic step();
    bit  alu_hs, ld_hs, have;
    wr_t a, l, sel, exp_w;
    #1;
    chk("alu_ready",  32'(alu_ready),  32'(fq.size() < DEPTH));
    chk("ld_ready",   32'(ld_ready),   32'(fq.size() == 0));
    chk("fifo_count", 32'(fifo_count), 32'(fq.size()));
    chk("hazard",     32'(hazard),     32'(m_match(chk_rs1_sel) | m_match(chk_rs2_sel)));

    a      = '{alu_rd_sel, alu_data};
    l      = '{ld_rd_sel, ld_data};
    alu_hs = alu_valid && (fq.size() < DEPTH);
    ld_hs  = ld_valid && (fq.size() == 0);
    ld_acc = ld_hs;
    if (ld_hs && l.rd != '0)  ret_q.push_back(l);
    if (alu_hs && a.rd != '0) ret_q.push_back(a);

    have = 1'b1;
    sel  = '{'0, '0};
    if (fq.size() != 0) begin
      sel = fq.pop_front();
      if (alu_hs) fq.push_back(a);
    end else if (ld_hs) begin
      sel = l;
      if (alu_hs) fq.push_back(a);
    end else if (alu_hs) begin
      sel = a;
    end else begin
      have = 1'b0;
    end
    if (have) begin
      m_we  = (sel.rd != '0);
      m_sel = sel.rd;
      m_rd  = sel.d;
    end else begin
      m_we = 1'b0;
    end

    @(posedge clk);
    #1;
    chk("wb_we",     32'(wb_we),     32'(m_we));
    chk("wb_rd_sel", 32'(wb_rd_sel), 32'(m_sel));
    chk("wb_rd",     wb_rd,          m_rd);
    if (wb_we === 1'b1) begin
      rf_dut[wb_rd_sel] = wb_rd;
      if (ret_q.size() == 0) begin
        chk("order_unexpected_write", 32'(wb_we), 32'd0);
      end else begin
        exp_w = ret_q.pop_front();
        chk("order_rd_sel", 32'(wb_rd_sel), 32'(exp_w.rd));
        chk("order_data",   wb_rd,          exp_w.d);
      end
    end
  endtask

  initial begin
    foreach (rf_dut[i]) rf_dut[i] = '0;
    rst_n       = 1'b0;
    alu_valid   = 1'b0;
    alu_rd_sel  = '0;
    alu_data    = '0;
    ld_valid    = 1'b0;
    ld_rd_sel   = '0;
    ld_data     = '0;
    chk_rs1_sel = 5'd1;
    chk_rs2_sel = 5'd2;
    ld_acc      = 1'b0;
    model_reset();

    // Reset state
    #1;
    chk("rst_wb_we",      32'(wb_we),      32'd0);
    chk("rst_wb_rd_sel",  32'(wb_rd_sel),  32'd0);
    chk("rst_wb_rd",      wb_rd,           32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_hazard",     32'(hazard),     32'd0);
    chk("rst_alu_ready",  32'(alu_ready),  32'd1);
    chk("rst_ld_ready",   32'(ld_ready),   32'd1);
    #10 rst_n = 1'b1;

    // Single ALU write bypasses the queue
    alu_valid = 1'b1; alu_rd_sel = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    idle();
    step();

    // Load and ALU collide with the queue empty: load first, ALU queued
    ld_valid  = 1'b1; ld_rd_sel  = 5'd3; ld_data  = 32'h11;
    alu_valid = 1'b1; alu_rd_sel = 5'd4; alu_data = 32'h22;
    step();
    idle();
    step();
    step();

    // Held load plus six back-to-back ALU results (8..13)
    ld_valid = 1'b1; ld_rd_sel = 5'd7; ld_data = 32'h77;
    for (int i = 0; i < 6; i++) begin
      alu_valid  = 1'b1;
      alu_rd_sel = AW'(8 + i);
      alu_data   = 32'h100 + 32'(i);
      step();
      if (ld_acc) ld_valid = 1'b0;
    end
    idle();
    repeat (3) step();

    // x0 target is consumed without a write
    alu_valid = 1'b1; alu_rd_sel = 5'd0; alu_data = 32'hBAD0;
    step();
    idle();
    step();

    // Hazard on a queued r9; rs2 = x0 never matches
    chk_rs1_sel = 5'd9; chk_rs2_sel = 5'd0;
    ld_valid  = 1'b1; ld_rd_sel  = 5'd1; ld_data  = 32'h1234;
    alu_valid = 1'b1; alu_rd_sel = 5'd9; alu_data = 32'h99;
    step();
    idle();
    repeat (4) step();

    // Same destination twice in flight: later write wins
    alu_valid = 1'b1; alu_rd_sel = 5'd2; alu_data = 32'h1;
    step();
    alu_rd_sel = 5'd2; alu_data = 32'h2;
    step();
    idle();
    repeat (2) step();
    chk("dup_final_r2", rf_dut[2], 32'h2);

    // Reset mid-stream with a write in flight and one queued
    ld_valid  = 1'b1; ld_rd_sel  = 5'd12; ld_data  = 32'hAA;
    alu_valid = 1'b1; alu_rd_sel = 5'd13; alu_data = 32'hBB;
    step();
    ld_valid = 1'b0;
    alu_rd_sel = 5'd14; alu_data = 32'hCC;
    step();
    idle();
    chk_rs1_sel = 5'd14; chk_rs2_sel = 5'd13;
    #1;
    chk("pre_rst_hazard", 32'(hazard), 32'(m_match(chk_rs1_sel) | m_match(chk_rs2_sel)));
    rst_n = 1'b0;
    #1;
    chk("midrst_wb_we",      32'(wb_we),      32'd0);
    chk("midrst_fifo_count", 32'(fifo_count), 32'd0);
    chk("midrst_hazard",     32'(hazard),     32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!ld_valid || ld_acc) begin
        ld_valid  = ($urandom_range(0, 3) == 0);
        ld_rd_sel = AW'($urandom_range(0, 7));
        ld_data   = $urandom;
      end
      alu_valid   = ($urandom_range(0, 2) != 0);
      alu_rd_sel  = AW'($urandom_range(0, 7));
      alu_data    = $urandom;
      chk_rs1_sel = AW'($urandom_range(0, 7));
      chk_rs2_sel = AW'($urandom_range(0, 7));
      step();
      if (ld_acc) ld_valid = 1'b0;
    end
    idle();
    repeat (4) step();
    chk("all_retired", 32'(ret_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
